// File: rtl/mean_removal_frame_ctrl.sv
// Frame sequencer for a bank of per-channel remove-mean cores.
// Resets the cores, broadcasts frames, serializes results.
module mean_removal_frame_ctrl #(
  parameter int N_CH    = 8,
  parameter int Q_in    = 32,
  parameter int RST_CYC = 4,
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_restart,
  input  logic [N_CH*Q_in-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 core_rst_n,
  output logic [N_CH*Q_in-1:0] core_data_in,
  output logic                 core_valid,
  input  logic [N_CH*Q_in-1:0] core_data_out,
  input  logic [N_CH-1:0]      core_out_valid,
  output logic [Q_in-1:0]      out_data,
  output logic [CW-1:0]        out_chan,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic                 sync_err,
  output logic                 busy
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] CNT_END = RW'(RST_CYC - 1);
  localparam logic [CW-1:0] IDX_END = CW'(N_CH - 1);

  logic [1:0]           state_q, state_d;
  logic [RW-1:0]        cnt_q, cnt_d;
  logic                 rstn_q, rstn_d;
  logic                 cv_q, cv_d;
  logic [N_CH*Q_in-1:0] cdi_q, cdi_d;
  logic [N_CH*Q_in-1:0] bank_q, bank_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic                 ov_q, ov_d;
  logic                 ovr_q, ovr_d;
  logic                 serr_q, serr_d;

  logic cap;
  logic all_v;
  logic hs;

  assign cap   = |core_out_valid;
  assign all_v = &core_out_valid;
  assign hs    = ov_q & out_ready;

  // Next-state: restart first, then per-state sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rstn_d  = rstn_q;
    cv_d    = cv_q;
    cdi_d   = cdi_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    ov_d    = ov_q;
    ovr_d   = ovr_q;
    serr_d  = serr_q;
    if (cfg_restart) begin
      state_d = S_INIT;
      cnt_d   = '0;
      rstn_d  = 1'b0;
      cv_d    = 1'b0;
      idx_d   = '0;
      ov_d    = 1'b0;
      ovr_d   = 1'b0;
      serr_d  = 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          cv_d = 1'b0;
          if (cnt_q == CNT_END) begin
            state_d = S_IDLE;
            rstn_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          cv_d = frame_valid;
          if (frame_valid) cdi_d = frame_data;
          if (cap) begin
            for (int k = 0; k < N_CH; k++) begin
              if (core_out_valid[k])
                bank_d[k*Q_in +: Q_in] = core_data_out[k*Q_in +: Q_in];
            end
            if (!all_v) serr_d = 1'b1;
            state_d = S_DRAIN;
            idx_d   = '0;
            ov_d    = 1'b1;
          end
        end
        S_DRAIN: begin
          cv_d = frame_valid;
          if (frame_valid) cdi_d = frame_data;
          if (cap) begin
            ovr_d = 1'b1;
            if (!all_v) serr_d = 1'b1;
          end
          if (hs) begin
            if (idx_q == IDX_END) begin
              ov_d    = 1'b0;
              idx_d   = '0;
              state_d = S_IDLE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_INIT;
          cnt_d   = '0;
          rstn_d  = 1'b0;
          cv_d    = 1'b0;
          ov_d    = 1'b0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rstn_q  <= 1'b0;
      cv_q    <= 1'b0;
      cdi_q   <= '0;
      bank_q  <= '0;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      ovr_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
      cv_q    <= cv_d;
      cdi_q   <= cdi_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      ovr_q   <= ovr_d;
      serr_q  <= serr_d;
    end
  end

  assign core_rst_n   = rstn_q;
  assign core_valid   = cv_q;
  assign core_data_in = cdi_q;
  assign out_data     = bank_q[idx_q*Q_in +: Q_in];
  assign out_chan     = idx_q;
  assign out_last     = ov_q & (idx_q == IDX_END);
  assign out_valid    = ov_q;
  assign overrun      = ovr_q;
  assign sync_err     = serr_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/mean_removal_frame_ctrl.md
Name: mean_removal_frame_ctrl

Overview:
Sequences a bank of N_CH per-channel remove-mean cores fed by the ADS1299 frame stream. It issues a timed reset to the cores and registers and broadcasts each incoming frame to all cores. It then captures their parallel results and serializes them, one channel per beat, onto a single ready/valid stream for the downstream SSVEP logic. It flags overruns and core misalignment with sticky status bits.

Parameters:
N_CH, 8, number of channels and cores.
Q_in, 32, sample width in bits (signed).
RST_CYC, 4, number of cycles core_rst_n is held low in INIT (>=1).

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
cfg_restart  in  1  single-cycle pulse that re-runs the INIT sequence.
frame_data  in  N_CH*Q_in  packed frame; channel k occupies bits [k*Q_in +: Q_in].
frame_valid  in  1  one-cycle strobe per frame. The source cannot stall.
core_rst_n  out  1  active-low reset to all cores.
core_data_in  out  N_CH*Q_in  registered frame_data, broadcast to the cores.
core_valid  out  1  registered frame_valid, sent to every core's data_in_valid.
core_data_out  in  N_CH*Q_in  packed core results.
core_out_valid  in  N_CH  per-core data_out_valid.
out_data  out  Q_in  serialized result (signed).
out_chan  out  clog2(N_CH)  channel index of out_data.
out_last  out  1  high on the beat for channel N_CH-1.
out_valid  out  1  output valid.
out_ready  in  1  downstream ready.
overrun  out  1  sticky: results arrived while a drain was still in progress.
sync_err  out  1  sticky: core_out_valid bits were not all equal.
busy  out  1  high in INIT or DRAIN.

Behaviour:
- Reset values (reset=1 at a clock edge): state=INIT, init counter=0, core_rst_n=0, core_valid=0, core_data_in=0, out_valid=0, out_data=0, out_chan=0, out_last=0, overrun=0, sync_err=0, busy=1.
- States: INIT, IDLE, DRAIN.
- INIT:
  - core_rst_n=0 for exactly RST_CYC cycles, then the state goes to IDLE and core_rst_n=1 from that cycle on.
  - frame_valid is ignored: core_valid stays 0, and no flags are set.
- Forwarding (IDLE and DRAIN):
  - core_valid <= frame_valid and core_data_in <= frame_data, giving 1 cycle of latency.
  - core_data_in holds its value when frame_valid=0.
- Capture: the capture condition is any bit of core_out_valid set.
  - If not all bits are set, sync_err <= 1. Only the valid channels are captured; the others keep their old bank value.
  - In IDLE: latch all N_CH results into the bank, go to DRAIN with idx=0, and set out_valid=1 the next cycle. Latency from core_out_valid to the first beat is 1 cycle.
  - In DRAIN: overrun <= 1. The new results are discarded and the current drain continues unchanged.
- DRAIN:
  - out_data=bank[idx], out_chan=idx, out_last=(idx==N_CH-1).
  - out_data, out_chan and out_last stay stable while out_valid=1 and out_ready=0.
  - When out_valid and out_ready are both high: if idx<N_CH-1 then idx++, otherwise out_valid <= 0 and the state goes to IDLE.
  - A capture condition in the same cycle as the final handshake counts as arriving in DRAIN: it sets overrun and is discarded.
- Minimum frame spacing without overrun is N_CH+1 cycles, assuming out_ready is held high.
- cfg_restart=1 in any state:
  - next state is INIT, init counter=0, core_rst_n=0, out_valid=0, core_valid=0.
  - the bank is not cleared; overrun and sync_err are cleared.
  - cfg_restart has priority over capture, handshake and frame_valid in the same cycle.
- Precedence: reset has priority over cfg_restart.
- The block does no arithmetic on data; results are passed through bit-exact.
- The core warm-up period (M frames with no output) is transparent to this block: IDLE persists until the first core_out_valid.

Test Plan:
1. Assert reset for 2 cycles, then release -> core_rst_n=0 for exactly 4 cycles, busy=1 for those 4 cycles, then core_rst_n=1, busy=0, and all outputs at their reset values.
2. In IDLE, frame_valid with channel k = 100+k -> core_valid=1 and core_data_in matches exactly 1 cycle later. A frame_valid during INIT produces no core_valid.
3. In IDLE with out_ready=1, core_out_valid=8'hFF and core_data_out channel k = -k -> 8 consecutive beats: out_chan 0..7, out_data 0,-1,..,-7, out_last only on chan 7, then out_valid=0 and the state returns to IDLE.
4. Same as scenario 3 but out_ready toggling 1,0,0,1,... -> each beat holds stable while out_ready=0, no beat is lost or duplicated, and 8 beats are delivered in total.
5. A second core_out_valid=8'hFF arrives 3 cycles into a drain -> overrun=1 and stays set, and the drain completes with the first frame's values. A following cfg_restart clears overrun.
6. core_out_valid=8'h7F -> sync_err=1. cfg_restart asserted in the same cycle as a capture -> INIT is entered, out_valid stays 0, and core_rst_n is low for 4 cycles.
